// File: rtl/conv_pkg.sv
// Shared constants, types and the generator-polynomial helper for the
// rate-1/2 K=3 convolutional encoder (G0=111, G1=101).
package conv_pkg;

  localparam int         K        = 3;
  localparam logic [2:0] G0       = 3'b111;
  localparam logic [2:0] G1       = 3'b101;
  localparam int         TAIL_LEN = 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

  typedef logic [1:0] sym_t;

  // Tap vector is {u, s[0], s[1]}: MSB of a generator multiplies the newest bit.
  function automatic sym_t conv_sym(input logic u, input logic [1:0] s);
    logic [K-1:0] taps;
    taps = {u, s[0], s[1]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Frame-in / symbol-out handshake bundle of conv_encoder_tx.
// master = encoder side, slave = frame producer / symbol consumer side.
interface conv_encoder_tx_if #(
  parameter int DATA_W = 8
);
  import conv_pkg::*;

  logic              frame_valid_i;
  logic              frame_ready_o;
  logic [DATA_W-1:0] frame_data_i;
  logic              sym_valid_o;
  logic              sym_ready_i;
  sym_t              sym_o;
  logic              sym_last_o;
  logic              busy_o;

  modport master (
    input  frame_valid_i,
    input  frame_data_i,
    input  sym_ready_i,
    output frame_ready_o,
    output sym_valid_o,
    output sym_o,
    output sym_last_o,
    output busy_o
  );

  modport slave (
    output frame_valid_i,
    output frame_data_i,
    output sym_ready_i,
    input  frame_ready_o,
    input  sym_valid_o,
    input  sym_o,
    input  sym_last_o,
    input  busy_o
  );

endinterface

// File: rtl/conv_enc_step.sv
// One trellis step of the shift-left K=3 encoder: (u, s) -> (symbol, next state).
module conv_enc_step
  import conv_pkg::*;
(
  input  logic       u,
  input  logic [1:0] s,
  output sym_t       sym,
  output logic [1:0] s_next
);

  assign sym    = conv_sym(u, s);
  assign s_next = {s[0], u};

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder: accepts a frame, emits one 2-bit symbol per cycle.
// Define CONV_TAIL_EN to append two zero-tail symbols per frame and restart from S0.
module conv_encoder_tx
  import conv_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  conv_encoder_tx_if.master bus
);

  localparam int              CNT_W     = $clog2(DATA_W + TAIL_LEN);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
`ifdef CONV_TAIL_EN
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] TAIL_PRE  = CNT_W'(TAIL_LEN - 2);
`else
  localparam logic [CNT_W-1:0] LAST_PRE  = CNT_W'(DATA_W - 2);
`endif

  enc_state_t        state_reg;
  logic [DATA_W-2:0] rem_reg;
  logic [1:0]        s_reg;
  logic [CNT_W-1:0]  cnt_reg;
  sym_t              sym_reg;
  logic              sym_valid_reg;
  logic              sym_last_reg;
  logic              frame_ready_reg;
  logic              busy_reg;

  logic              xfer;
  logic              u_in;
  logic [1:0]        s_in;
  logic [1:0]        s_start;
  sym_t              step_sym;
  logic [1:0]        step_s_next;

  // s_reg is the state after the symbol currently held in sym_reg, so a single
  // step instance precomputes the next symbol for either acceptance or a transfer.
`ifdef CONV_TAIL_EN
  assign s_start = 2'b00;
`else
  assign s_start = s_reg;
`endif

  assign xfer = sym_valid_reg && bus.sym_ready_i;

  always_comb begin
    u_in = rem_reg[DATA_W-2];
    s_in = s_reg;
    if (state_reg == IDLE) begin
      u_in = bus.frame_data_i[DATA_W-1];
      s_in = s_start;
    end
  end

  conv_enc_step u_step (
    .u      (u_in),
    .s      (s_in),
    .sym    (step_sym),
    .s_next (step_s_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rem_reg         <= '0;
      s_reg           <= 2'b00;
      cnt_reg         <= '0;
      sym_reg         <= 2'b00;
      sym_valid_reg   <= 1'b0;
      sym_last_reg    <= 1'b0;
      frame_ready_reg <= 1'b1;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.frame_valid_i && frame_ready_reg) begin
            rem_reg         <= bus.frame_data_i[DATA_W-2:0];
            cnt_reg         <= '0;
            sym_reg         <= step_sym;
            s_reg           <= step_s_next;
            sym_valid_reg   <= 1'b1;
            sym_last_reg    <= 1'b0;
            frame_ready_reg <= 1'b0;
            busy_reg        <= 1'b1;
            state_reg       <= DATA;
          end
        end

        DATA: begin
          if (xfer) begin
            if (cnt_reg == LAST_DATA) begin
`ifdef CONV_TAIL_EN
              // rem_reg is all zeros by now, so the step encodes the first tail bit.
              cnt_reg      <= '0;
              sym_reg      <= step_sym;
              s_reg        <= step_s_next;
              rem_reg      <= rem_reg << 1;
              sym_last_reg <= 1'b0;
              state_reg    <= TAIL;
`else
              sym_valid_reg   <= 1'b0;
              sym_last_reg    <= 1'b0;
              frame_ready_reg <= 1'b1;
              busy_reg        <= 1'b0;
              state_reg       <= IDLE;
`endif
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
              sym_reg <= step_sym;
              s_reg   <= step_s_next;
              rem_reg <= rem_reg << 1;
`ifdef CONV_TAIL_EN
              sym_last_reg <= 1'b0;
`else
              sym_last_reg <= (cnt_reg == LAST_PRE);
`endif
            end
          end
        end

`ifdef CONV_TAIL_EN
        TAIL: begin
          if (xfer) begin
            if (cnt_reg == TAIL_LAST) begin
              sym_valid_reg   <= 1'b0;
              sym_last_reg    <= 1'b0;
              frame_ready_reg <= 1'b1;
              busy_reg        <= 1'b0;
              state_reg       <= IDLE;
            end else begin
              cnt_reg      <= cnt_reg + 1'b1;
              sym_reg      <= step_sym;
              s_reg        <= step_s_next;
              rem_reg      <= rem_reg << 1;
              sym_last_reg <= (cnt_reg == TAIL_PRE);
            end
          end
        end
`endif

        default: begin
          state_reg       <= IDLE;
          sym_valid_reg   <= 1'b0;
          sym_last_reg    <= 1'b0;
          frame_ready_reg <= 1'b1;
          busy_reg        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_ready_o = frame_ready_reg;
  assign bus.sym_valid_o   = sym_valid_reg;
  assign bus.sym_o         = sym_reg;
  assign bus.sym_last_o    = sym_last_reg;
  assign bus.busy_o        = busy_reg;

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Rate-1/2, K=3 convolutional encoder (generators G0=111, G1=101). It is the transmit-side counterpart of the Viterbi decoding chain and uses the same shift-left trellis.
- Accepts a parallel frame over a valid/ready handshake and serializes it MSB-first.
- Emits one 2-bit code symbol per cycle over a valid/ready stream, optionally followed by 2 zero-tail symbols that terminate the trellis in S0.
- Drives the decoder's serial symbol input in loopback benches and is the reference stimulus generator for the core.

Parameters:
- DATA_W, 8, frame width in information bits (>=2).
- CNT_W, $clog2(DATA_W+2), symbol counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- frame_valid_i  in  1  frame_data_i holds a valid frame.
- frame_ready_o  out  1  encoder can accept a frame (high only in IDLE).
- frame_data_i  in  DATA_W  information bits; bit DATA_W-1 is encoded first.
- sym_valid_o  out  1  sym_o is valid.
- sym_ready_i  in  1  downstream accepts sym_o.
- sym_o  out  2  code symbol; [1]=G0 output, [0]=G1 output.
- sym_last_o  out  1  high with the final symbol of the frame.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - frame_ready_o=1; all other outputs 0.
  - Encoder state s=2'b00, counter=0, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately. No further symbols appear; the partial frame is discarded.
- Encoder state s[1:0]: s[0] is the newest past bit, s[1] the older one. For input u:
  - g0 = u^s[0]^s[1]
  - g1 = u^s[1]
  - next s = {s[0],u}
  - Trellis check: S0->S1 gives 11, S1->S2 gives 10, S2->S0 gives 11, S3->S3 gives 10.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: frame_ready_o=1. On frame_valid_i&&frame_ready_o, latch frame_data_i into a shift register, clear the counter, go to DATA. frame_data_i is sampled only at acceptance.
  - DATA:
    - The output register holds the symbol for the current MSB.
    - A symbol is transferred when sym_valid_o&&sym_ready_i. Each transfer updates s, shifts the data register left and increments the counter.
    - After DATA_W transfers, go to TAIL (tail enabled) or IDLE (tail disabled).
  - TAIL: encode u=0 twice, then go to IDLE. At the end s==00.
- Latency and handshake:
  - The first symbol is valid the cycle after frame acceptance.
  - Full throughput: one symbol per cycle while sym_ready_i=1.
  - While sym_valid_o&&!sym_ready_i, sym_o, sym_last_o and internal state hold stable.
  - sym_valid_o never drops without a transfer.
- Frame boundaries:
  - sym_last_o is asserted on symbol DATA_W+1 (tail enabled) or DATA_W-1 (disabled), indexing from 0.
  - After the last transfer, FSM returns to IDLE and frame_ready_o rises the next cycle. The bubble between frames is exactly 1 cycle.
- Counter: CNT_W bits, never wraps within a frame. It compares against DATA_W-1 and 1 (tail) for terminal detection.
- frame_valid_i asserted while busy is ignored and not lost. The upstream holds it until frame_ready_o is high.

Optional Feature:
- Macro: CONV_TAIL_EN.
- Defined: 2 zero-tail symbols are appended per frame (DATA_W+2 symbols). s==00 at every frame start.
- Undefined:
  - TAIL state is removed and each frame yields DATA_W symbols.
  - s carries over between frames (continuous stream for the register-exchange decoder); only rst clears it.

Decomposition:
- Package conv_pkg holds:
  - K=3, G0=3'b111, G1=3'b101, TAIL_LEN=2.
  - FSM state typedef {IDLE,DATA,TAIL}.
  - Symbol typedef logic[1:0].
- One natural sub-module: conv_enc_step, combinational (u, s) -> (sym, s_next). It is reused by the bench's golden model.

Test Plan:
- With CONV_TAIL_EN, frame 8'hB0, sym_ready_i=1 -> symbols 11,10,00,01,01,11,00,00,00,00. sym_last_o is high on the 10th symbol only; first symbol 1 cycle after acceptance.
- With CONV_TAIL_EN, 8'hFF -> 11,01,10,10,10,10,10,10,01,11; internal s==00 afterwards.
- Without CONV_TAIL_EN, 8'hFF then 8'h00 -> 11,01,10×6 then 01,11,00×6. sym_last_o is high on each 8th symbol; 1-cycle bubble between frames.
- Random sym_ready_i backpressure (50%) on 8'hB0: the symbol sequence is identical to the first scenario, and sym_o stays stable on every stalled cycle.
- Assert rst during symbol 4 of a frame -> next cycle sym_valid_o=0, busy_o=0, frame_ready_o=1. A new frame 8'h80 then yields 11,10,11,00… from S0.
- Hold frame_valid_i high with changing frame_data_i while busy -> a new frame is accepted only in IDLE. Symbols match the data sampled at acceptance.
